// File: rtl/usb_rx_ctrl.sv
// Full-speed USB receive front end: 4x oversampled line recovery, NRZI decode,
// SYNC detection, bit unstuffing, byte assembly and EOP/error reporting.
`timescale 1ns/1ps

module usb_rx_ctrl #(
    parameter int unsigned SAMPLE_PHASE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_j,
    input  logic       rx_se0,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pkt_active,
    output logic       pkt_end,
    output logic       rx_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam logic [1:0] SAMPLE_PH = 2'(SAMPLE_PHASE);

    state_t     state_r;
    logic [1:0] phase_r;
    logic       line_prev_r;
    logic       prev_samp_r;
    logic [2:0] zero_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [2:0] ones_cnt_r;
    logic [7:0] shift_r;
    logic       bad_r;

    logic       strobe_s;
    logic       edge_s;
    logic       nrzi_bit_s;
    logic [7:0] shift_next_s;

    // Line edge detection, sample strobe and NRZI-decoded bit
    always_comb begin
        strobe_s     = (phase_r == SAMPLE_PH);
        edge_s       = (!rx_se0) && (rx_j != line_prev_r);
        nrzi_bit_s   = (rx_j == prev_samp_r);
        shift_next_s = {nrzi_bit_s, shift_r[7:1]};
    end

    // Phase counter re-aligns to every J/K transition so samples land mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev_r <= 1'b1;
            phase_r     <= 2'd0;
        end else begin
            line_prev_r <= rx_j;
            if (edge_s) begin
                phase_r <= 2'd0;
            end else begin
                phase_r <= phase_r + 2'd1;
            end
        end
    end

    // Packet state machine with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            prev_samp_r <= 1'b1;
            zero_cnt_r  <= 3'd0;
            bit_cnt_r   <= 3'd0;
            ones_cnt_r  <= 3'd0;
            shift_r     <= 8'h00;
            bad_r       <= 1'b0;
            data        <= 8'h00;
            data_valid  <= 1'b0;
            pkt_active  <= 1'b0;
            pkt_end     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            pkt_end    <= 1'b0;
            rx_err     <= 1'b0;
            if (strobe_s) begin
                prev_samp_r <= rx_j;
                case (state_r)
                    ST_IDLE: begin
                        if (!rx_se0 && !rx_j) begin
                            state_r    <= ST_SYNC;
                            zero_cnt_r <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (rx_se0) begin
                            state_r <= ST_IDLE;
                        end else if (!nrzi_bit_s) begin
                            if (zero_cnt_r != 3'd7) begin
                                zero_cnt_r <= zero_cnt_r + 3'd1;
                            end
                        end else if (zero_cnt_r >= 3'd5) begin
                            state_r    <= ST_DATA;
                            pkt_active <= 1'b1;
                            bad_r      <= 1'b0;
                            bit_cnt_r  <= 3'd0;
                            ones_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (rx_se0) begin
                            state_r <= ST_EOP;
                            if (bit_cnt_r != 3'd0) begin
                                bad_r <= 1'b1;
                            end
                        end else if (ones_cnt_r == 3'd6) begin
                            // Stuff slot: a 0 is dropped, a 1 is a stuffing violation
                            if (nrzi_bit_s) begin
                                state_r <= ST_ABORT;
                                bad_r   <= 1'b1;
                            end else begin
                                ones_cnt_r <= 3'd0;
                            end
                        end else begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (nrzi_bit_s) begin
                                ones_cnt_r <= ones_cnt_r + 3'd1;
                            end else begin
                                ones_cnt_r <= 3'd0;
                            end
                            if (bit_cnt_r == 3'd7) begin
                                data       <= shift_next_s;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (!rx_se0) begin
                            state_r     <= ST_IDLE;
                            prev_samp_r <= 1'b1;
                            pkt_end     <= 1'b1;
                            pkt_active  <= 1'b0;
                            rx_err      <= rx_j ? bad_r : 1'b1;
                        end
                    end
                    ST_ABORT: begin
                        bad_r <= 1'b1;
                        if (rx_se0) begin
                            state_r <= ST_EOP;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: table of packets driven at 4 clk/bit with an
// NRZI/stuffing encoder, plus a hand-written mid-packet reset sequence.
`timescale 1ns/1ps

module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_j = 1'b1;
    logic       rx_se0 = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       pkt_active;
    logic       pkt_end;
    logic       rx_err;

    usb_rx_ctrl #(.SAMPLE_PHASE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_j       (rx_j),
        .rx_se0     (rx_se0),
        .data       (data),
        .data_valid (data_valid),
        .pkt_active (pkt_active),
        .pkt_end    (pkt_end),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output monitor: cumulative event counts, sampled on the inactive edge
    int         mon_valid = 0;
    int         mon_end   = 0;
    int         mon_err   = 0;
    int         mon_stray = 0;
    int         mon_act   = 0;
    logic [7:0] dq[$];

    always @(negedge clk) begin
        if (data_valid) begin
            dq.push_back(data);
            mon_valid++;
        end
        if (pkt_end) begin
            mon_end++;
            if (rx_err) mon_err++;
        end
        if (rx_err && !pkt_end) mon_stray++;
        if (data_valid && pkt_end) mon_stray++;
        if (pkt_active) mon_act++;
    end

    task automatic slot(input logic j, input logic se0);
        rx_j   = j;
        rx_se0 = se0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) slot(1'b1, 1'b0);
    endtask

    task automatic send_sync(input logic [1:0] t);
        logic [7:0] pat;
        int         len;
        case (t)
            2'd0:    begin pat = 8'b0010_1010; len = 8; end  // KJKJKJKK
            2'd1:    begin pat = 8'b0000_1010; len = 6; end  // KJKJKK
            default: begin pat = 8'b0000_1010; len = 4; end  // KJKJ
        endcase
        for (int k = 0; k < len; k++) slot(pat[k], 1'b0);
    endtask

    // NRZI encode from K (last SYNC symbol), optionally inserting stuff bits
    task automatic send_data(input logic [15:0] payload, input int nbits, input logic stuff_en);
        logic level;
        int   ones;
        level = 1'b0;
        ones  = 0;
        for (int k = 0; k < nbits; k++) begin
            if (stuff_en && ones == 6) begin
                level = ~level;
                slot(level, 1'b0);
                ones = 0;
            end
            if (payload[k]) begin
                ones++;
            end else begin
                ones  = 0;
                level = ~level;
            end
            slot(level, 1'b0);
        end
    endtask

    task automatic send_eop();
        slot(1'b0, 1'b1);
        slot(1'b0, 1'b1);
        slot(1'b1, 1'b0);
    endtask

    // Release reset so that line slots start right after a phase-3 edge
    task automatic release_reset();
        rx_j   = 1'b1;
        rx_se0 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},       32'(data),       32'h0);
        check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        check({tag, "_pkt_active"}, 32'(pkt_active), 32'h0);
        check({tag, "_pkt_end"},    32'(pkt_end),    32'h0);
        check({tag, "_rx_err"},     32'(rx_err),     32'h0);
    endtask

    typedef struct packed {
        logic [1:0]  sync_type;
        logic [4:0]  nbits;
        logic [15:0] payload;
        logic        stuff_en;
        logic        eop;
        logic [1:0]  exp_nvalid;
        logic [7:0]  exp_d0;
        logic [7:0]  exp_d1;
        logic        exp_end;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    initial begin
        int         bv, be, berr, bs, bq, ba;
        logic [7:0] last_byte;
        logic [31:0] got;

        vecs[0] = '{2'd0, 5'd8,  16'h00A5, 1'b1, 1'b1, 2'd1, 8'hA5, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{2'd0, 5'd16, 16'h01FF, 1'b1, 1'b1, 2'd2, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{2'd0, 5'd12, 16'h0A3C, 1'b1, 1'b1, 2'd1, 8'h3C, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{2'd1, 5'd8,  16'h005A, 1'b1, 1'b1, 2'd1, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 5'd7,  16'h007F, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 5'd8,  16'h0000, 1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{2'd2, 5'd0,  16'h0000, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        release_reset();
        idle(4);
        last_byte = 8'h00;

        for (int i = 0; i < NVEC; i++) begin
            bv = mon_valid; be = mon_end; berr = mon_err;
            bs = mon_stray; bq = dq.size(); ba = mon_act;
            send_sync(vecs[i].sync_type);
            if (vecs[i].nbits != 5'd0) send_data(vecs[i].payload, int'(vecs[i].nbits), vecs[i].stuff_en);
            if (vecs[i].eop) send_eop();
            idle(3);
            check($sformatf("vec%0d_nvalid", i), 32'(mon_valid - bv), 32'(vecs[i].exp_nvalid));
            if (vecs[i].exp_nvalid >= 2'd1) begin
                got = (dq.size() > bq) ? 32'(dq[bq]) : 32'hDEAD;
                check($sformatf("vec%0d_byte0", i), got, 32'(vecs[i].exp_d0));
                last_byte = vecs[i].exp_d0;
            end
            if (vecs[i].exp_nvalid == 2'd2) begin
                got = (dq.size() > bq + 1) ? 32'(dq[bq + 1]) : 32'hDEAD;
                check($sformatf("vec%0d_byte1", i), got, 32'(vecs[i].exp_d1));
                last_byte = vecs[i].exp_d1;
            end
            check($sformatf("vec%0d_pkt_end", i), 32'(mon_end - be), 32'(vecs[i].exp_end));
            check($sformatf("vec%0d_rx_err", i), 32'(mon_err - berr), 32'(vecs[i].exp_end & vecs[i].exp_err));
            check($sformatf("vec%0d_stray", i), 32'(mon_stray - bs), 32'h0);
            check($sformatf("vec%0d_active_seen", i), 32'(mon_act > ba), 32'(vecs[i].exp_end));
            check($sformatf("vec%0d_active_end", i), 32'(pkt_active), 32'h0);
            check($sformatf("vec%0d_data_hold", i), 32'(data), 32'(last_byte));
        end

        // Reset asserted during the second byte of a packet
        bv = mon_valid; bq = dq.size();
        send_sync(2'd0);
        send_data(16'h0A11, 12, 1'b1);
        repeat (2) @(posedge clk);
        check("midrst_active_before", 32'(pkt_active), 32'h1);
        check("midrst_nvalid_before", 32'(mon_valid - bv), 32'h1);
        got = (dq.size() > bq) ? 32'(dq[bq]) : 32'hDEAD;
        check("midrst_byte0", got, 32'h11);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        be = mon_end;
        release_reset();
        idle(4);
        check("midrst_no_pkt_end", 32'(mon_end - be), 32'h0);

        bv = mon_valid; be = mon_end; berr = mon_err; bq = dq.size();
        send_sync(2'd0);
        send_data(16'h00C3, 8, 1'b1);
        send_eop();
        idle(3);
        check("post_rst_nvalid", 32'(mon_valid - bv), 32'h1);
        got = (dq.size() > bq) ? 32'(dq[bq]) : 32'hDEAD;
        check("post_rst_byte", got, 32'hC3);
        check("post_rst_pkt_end", 32'(mon_end - be), 32'h1);
        check("post_rst_rx_err", 32'(mon_err - berr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
